// File: rtl/button_stepper.sv
// Debounced push-button that steps a one-hot LED position up or down,
// with hold-to-auto-repeat after a long press.
module button_stepper #(
   parameter int DEBOUNCE_CYCLES = 120000,
   parameter int HOLD_CYCLES     = 6000000,
   parameter int REPEAT_CYCLES   = 2400000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_n,
   input  logic       dir,
   output logic       LED1,
   output logic       LED2,
   output logic       LED3,
   output logic       LED4,
   output logic       LED5,
   output logic [1:0] index,
   output logic       step
);

   localparam int MAX_A      = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
   localparam int MAX_CYCLES = (MAX_A > REPEAT_CYCLES) ? MAX_A : REPEAT_CYCLES;
   localparam int CW         = $clog2(MAX_CYCLES);

   localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);

   localparam logic [2:0] S_IDLE       = 3'd0;
   localparam logic [2:0] S_DB_PRESS   = 3'd1;
   localparam logic [2:0] S_PRESSED    = 3'd2;
   localparam logic [2:0] S_REPEAT     = 3'd3;
   localparam logic [2:0] S_DB_RELEASE = 3'd4;

   logic          r_btn_meta, r_btn_sync, r_dir_meta, r_dir_sync;
   logic [2:0]    r_state;
   logic [CW-1:0] r_cnt;
   logic          r_held, r_step;
   logic [1:0]    r_index;
   logic [3:0]    r_led;

   logic          w_btn_s;
   logic [2:0]    w_state_nxt;
   logic [CW-1:0] w_cnt_nxt;
   logic          w_held_nxt, w_step_nxt;
   logic [1:0]    w_index_nxt;

   assign w_btn_s = ~r_btn_sync;

   // Two-flop synchronizers; reset to the released / up positions.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_btn_meta <= 1'b1;
         r_btn_sync <= 1'b1;
         r_dir_meta <= 1'b0;
         r_dir_sync <= 1'b0;
      end else begin
         r_btn_meta <= btn_n;
         r_btn_sync <= r_btn_meta;
         r_dir_meta <= dir;
         r_dir_sync <= r_dir_meta;
      end
   end

   // Next-state logic; a release always beats a coincident step.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt + CNT_ONE;
      w_held_nxt  = r_held;
      w_step_nxt  = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_cnt_nxt = CNT_ZERO;
            if (w_btn_s) begin
               w_state_nxt = S_DB_PRESS;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_DB_PRESS: begin
            if (!w_btn_s) begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = CNT_ZERO;
            end else if (r_cnt == DB_LAST) begin
               w_state_nxt = S_PRESSED;
               w_cnt_nxt   = CNT_ZERO;
               w_step_nxt  = 1'b1;
            end else begin
               w_state_nxt = S_DB_PRESS;
            end
         end
         S_PRESSED: begin
            if (!w_btn_s) begin
               w_state_nxt = S_DB_RELEASE;
               w_cnt_nxt   = CNT_ZERO;
            end else if (r_cnt == HOLD_LAST) begin
               w_state_nxt = S_REPEAT;
               w_cnt_nxt   = CNT_ZERO;
               w_step_nxt  = 1'b1;
               w_held_nxt  = 1'b1;
            end else begin
               w_state_nxt = S_PRESSED;
            end
         end
         S_REPEAT: begin
            if (!w_btn_s) begin
               w_state_nxt = S_DB_RELEASE;
               w_cnt_nxt   = CNT_ZERO;
            end else if (r_cnt == REP_LAST) begin
               w_cnt_nxt  = CNT_ZERO;
               w_step_nxt = 1'b1;
            end else begin
               w_state_nxt = S_REPEAT;
            end
         end
         S_DB_RELEASE: begin
            if (w_btn_s) begin
               w_cnt_nxt = CNT_ZERO;
            end else if (r_cnt == DB_LAST) begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = CNT_ZERO;
               w_held_nxt  = 1'b0;
            end else begin
               w_state_nxt = S_DB_RELEASE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = CNT_ZERO;
            w_held_nxt  = 1'b0;
         end
      endcase

      if (w_step_nxt) begin
         if (r_dir_sync) begin
            w_index_nxt = r_index - 2'd1;
         end else begin
            w_index_nxt = r_index + 2'd1;
         end
      end else begin
         w_index_nxt = r_index;
      end
   end

   // State, counter and registered outputs; LEDs track the new index.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= CNT_ZERO;
         r_held  <= 1'b0;
         r_step  <= 1'b0;
         r_index <= 2'd0;
         r_led   <= 4'b0001;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_held  <= w_held_nxt;
         r_step  <= w_step_nxt;
         r_index <= w_index_nxt;
         r_led   <= 4'b0001 << w_index_nxt;
      end
   end

   assign LED1  = r_led[0];
   assign LED2  = r_led[1];
   assign LED3  = r_led[2];
   assign LED4  = r_led[3];
   assign LED5  = r_held;
   assign index = r_index;
   assign step  = r_step;

endmodule

// File: tb/tb_button_stepper.sv
// Self-checking bench for button_stepper: directed scenarios with literal
// expectations plus randomized button/dir/reset traffic against a run-length model.
module tb_button_stepper;

   localparam int D = 4;
   localparam int H = 20;
   localparam int R = 8;

   logic       clk = 1'b0;
   logic       rst, btn_n, dir;
   logic       LED1, LED2, LED3, LED4, LED5, step;
   logic [1:0] index;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int step_q[$];
   int held_rise = -1;
   int held_fall = -1;
   bit held_seen = 1'b0;
   bit prev_led5 = 1'b0;

   button_stepper #(.DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .REPEAT_CYCLES(R)) dut (
      .clk(clk), .rst(rst), .btn_n(btn_n), .dir(dir),
      .LED1(LED1), .LED2(LED2), .LED3(LED3), .LED4(LED4), .LED5(LED5),
      .index(index), .step(step)
   );

   always #5 clk = ~clk;

   // Model state: raw-input history, phase (waiting/accepted/releasing) and run length.
   typedef struct packed {
      bit       b1, b2, d1, d2;
      int       phase;
      int       run;
      bit [1:0] idx;
      bit       stp, held;
   } mstate_t;

   mstate_t ms;

   function automatic mstate_t mnext(mstate_t s, bit r, bit b, bit d);
      mstate_t n = s;
      bit fb, fd;
      if (r) begin
         n.b1 = 1'b1; n.b2 = 1'b1; n.d1 = 1'b0; n.d2 = 1'b0;
         n.phase = 0; n.run = 0; n.idx = 2'd0; n.stp = 1'b0; n.held = 1'b0;
         return n;
      end
      fb = !s.b2;
      fd = s.d2;
      n.b2 = s.b1; n.b1 = b; n.d2 = s.d1; n.d1 = d;
      n.stp = 1'b0;
      case (s.phase)
         0: begin
            // a press is accepted after D+1 consecutive pressed samples
            if (fb) begin
               n.run = s.run + 1;
               if (n.run == D + 1) begin
                  n.phase = 1; n.run = 0; n.stp = 1'b1;
               end
            end else begin
               n.run = 0;
            end
         end
         1: begin
            if (!fb) begin
               n.phase = 2; n.run = 0;
            end else begin
               n.run = s.run + 1;
               if (n.run >= H && ((n.run - H) % R) == 0) n.stp = 1'b1;
               if (n.run == H) n.held = 1'b1;
            end
         end
         default: begin
            if (fb) n.run = 0;
            else    n.run = s.run + 1;
            if (n.run == D) begin
               n.phase = 0; n.run = 0; n.held = 1'b0;
            end
         end
      endcase
      if (n.stp) n.idx = fd ? s.idx - 2'd1 : s.idx + 2'd1;
      return n;
   endfunction

   always @(posedge clk) begin
      ms  <= mnext(ms, rst, btn_n, dir);
      cyc <= cyc + 1;
   end

   // Per-cycle compare against the model, plus step/held event logging.
   initial begin
      logic [7:0] act, expv;
      forever begin
         @(negedge clk);
         if (cyc > 0) begin
            act  = {step, index, LED1, LED2, LED3, LED4, LED5};
            expv = {ms.stp, ms.idx, ms.idx == 2'd0, ms.idx == 2'd1,
                    ms.idx == 2'd2, ms.idx == 2'd3, ms.held};
            n_checks++;
            if (act !== expv) begin
               n_fail++;
               $display("FAIL model_cmp cyc=%0d got {step,index,LED1..5}=%b expected %b",
                        cyc, act, expv);
            end
            if (step === 1'b1) step_q.push_back(cyc);
            if (LED5 === 1'b1) held_seen = 1'b1;
            if (LED5 === 1'b1 && !prev_led5) held_rise = cyc;
            if (LED5 !== 1'b1 && prev_led5)  held_fall = cyc;
            prev_led5 = (LED5 === 1'b1);
         end
      end
   end

   task automatic chk(input string nm, input int act, input int exp_v);
      n_checks++;
      if (act != exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
   endtask

   task automatic clear_log();
      step_q.delete();
      held_seen = 1'b0;
      held_rise = -1;
      held_fall = -1;
   endtask

   task automatic press_for(input int n, output int k);
      btn_n = 1'b0;
      k = cyc + 1;
      tick(n);
      btn_n = 1'b1;
   endtask

   initial begin
      int k, r, len;
      int exp22[6];
      exp22 = '{6, 26, 34, 42, 50, 58};
      rst = 1'b1; btn_n = 1'b1; dir = 1'b0;
      tick(3);
      rst = 1'b0;

      // reset state
      chk("rst_led1", int'(LED1), 1);
      chk("rst_led2", int'(LED2), 0);
      chk("rst_led5", int'(LED5), 0);
      chk("rst_index", int'(index), 0);
      chk("rst_step", int'(step), 0);

      // clean press, dir up
      tick(3); clear_log();
      press_for(10, k);
      tick(20); #1;
      chk("clean_nsteps", step_q.size(), 1);
      chk("clean_edge", (step_q.size() > 0) ? step_q[0] - k : -1, 6);
      chk("clean_index", int'(index), 1);
      chk("clean_led2", int'(LED2), 1);
      chk("clean_held", int'(held_seen), 0);

      // bounce rejected
      do_reset(); tick(3); clear_log();
      btn_n = 1'b0; tick(3); btn_n = 1'b1; tick(1);
      btn_n = 1'b0; tick(3); btn_n = 1'b1; tick(20); #1;
      chk("bounce_nsteps", step_q.size(), 0);
      chk("bounce_index", int'(index), 0);

      // long hold with auto-repeat
      do_reset(); tick(3); clear_log();
      press_for(60, k);
      tick(20); #1;
      chk("hold_nsteps", step_q.size(), 6);
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("hold_edge%0d", i), (i < step_q.size()) ? step_q[i] - k : -1, exp22[i]);
      end
      chk("hold_index", int'(index), 2);
      chk("hold_rise", held_rise - k, 26);
      chk("hold_fall", held_fall - k, 66);

      // dir down from reset
      dir = 1'b1; do_reset(); tick(3); clear_log();
      press_for(10, k);
      tick(20); #1;
      chk("down_index", int'(index), 3);
      chk("down_led4", int'(LED4), 1);
      chk("down_nsteps", step_q.size(), 1);

      // release bounce
      dir = 1'b0; do_reset(); tick(3); clear_log();
      press_for(10, k);
      tick(2); btn_n = 1'b0; tick(1); btn_n = 1'b1; tick(16); #1;
      chk("relb_nsteps", step_q.size(), 1);
      chk("relb_index", int'(index), 1);

      // reset during repeat with button held
      do_reset(); tick(3); clear_log();
      btn_n = 1'b0; k = cyc + 1;
      tick(30); #1;
      chk("rrep_held_pre", int'(LED5), 1);
      rst = 1'b1; r = cyc + 1;
      tick(1);
      rst = 1'b0; #1;
      chk("rrep_index", int'(index), 0);
      chk("rrep_led1", int'(LED1), 1);
      chk("rrep_led5", int'(LED5), 0);
      chk("rrep_step", int'(step), 0);
      clear_log();
      tick(10); #1;
      chk("rrep_edge", (step_q.size() > 0) ? step_q[0] - r : -1, 7);
      btn_n = 1'b1; tick(20);

      // randomized traffic, checked by the per-cycle model compare
      do_reset();
      for (int it = 0; it < 250; it++) begin
         if ($urandom_range(0, 3) == 0) len = $urandom_range(20, 70);
         else                           len = $urandom_range(1, 8);
         btn_n = $urandom_range(0, 1) == 1;
         if ($urandom_range(0, 7) == 0) dir = ~dir;
         if ($urandom_range(0, 39) == 0) rst = 1'b1;
         tick(1);
         rst = 1'b0;
         tick(len);
      end
      btn_n = 1'b1;
      tick(30);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
